// File: rtl/toggle_handshake_rx_if.sv
// Bus bundle between a toggle-handshake sender/consumer and toggle_handshake_rx.
//   req_toggle / req_data : request side, driven by the sender (async to receiver clk)
//   ack_toggle            : acknowledge toggle returned to the sender
//   dout / dout_valid / dout_ready : first-word-fall-through drain port
//   level / full          : FIFO occupancy status
// Modports: master = sender/consumer side, slave = receiver.
interface toggle_handshake_rx_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic              req_toggle;
   logic [DATA_W-1:0] req_data;
   logic              ack_toggle;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic [LVL_W-1:0]  level;
   logic              full;

   modport master (
      output req_toggle, req_data, dout_ready,
      input  ack_toggle, dout, dout_valid, level, full
   );

   modport slave (
      input  req_toggle, req_data, dout_ready,
      output ack_toggle, dout, dout_valid, level, full
   );
endinterface

// File: rtl/toggle_handshake_rx.sv
// Receiving end of a toggle-flag data crossing. Synchronises the sender's request
// toggle, captures the sender-held word into a small FIFO, and returns an acknowledge
// toggle equal to the request level of the last accepted word. Local logic drains
// the FIFO through a first-word-fall-through valid/ready port.
// Ports:
//   clk    destination-domain clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    toggle_handshake_rx_if.slave (req_toggle, req_data, ack_toggle,
//          dout, dout_valid, dout_ready, level, full)
module toggle_handshake_rx #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   toggle_handshake_rx_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [SYNC_STAGES-1:0] syncChain;
   logic                   reqS;
   logic                   seenLvl;
   logic                   ackQ;
   logic                   pending;
   logic                   push;
   logic                   pop;
   logic                   validQ;
   logic                   fullQ;
   logic [PTR_W-1:0]       wrPtr;
   logic [PTR_W-1:0]       rdPtr;
   logic [LVL_W-1:0]       levelQ;
   logic [LVL_W-1:0]       levelNext;
   logic [DATA_W-1:0]      mem [DEPTH];

   // Request toggle synchroniser; only the last stage feeds logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncChain <= '0;
      end else begin
         syncChain <= {syncChain[SYNC_STAGES-2:0], bus.req_toggle};
      end
   end

   assign reqS    = syncChain[SYNC_STAGES-1];
   assign pending = reqS ^ seenLvl;
   // Push uses the registered full flag: a same-edge pop frees space only for the next edge.
   assign push    = pending & ~fullQ;
   assign pop     = validQ & bus.dout_ready;

   // Occupancy update: both or neither leaves it unchanged.
   always_comb begin
      levelNext = levelQ;
      if (push && !pop) begin
         levelNext = levelQ + LVL_W'(1);
      end else if (pop && !push) begin
         levelNext = levelQ - LVL_W'(1);
      end
   end

   // Control state: pointers, occupancy, flags and the acknowledge toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seenLvl <= 1'b0;
         ackQ    <= 1'b0;
         wrPtr   <= '0;
         rdPtr   <= '0;
         levelQ  <= '0;
         validQ  <= 1'b0;
         fullQ   <= 1'b0;
      end else begin
         if (push) begin
            wrPtr   <= wrPtr + PTR_W'(1);
            seenLvl <= reqS;
            ackQ    <= reqS;
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         levelQ <= levelNext;
         validQ <= (levelNext != '0);
         fullQ  <= (levelNext == LVL_W'(DEPTH));
      end
   end

   // Storage is not reset; dout is meaningless while dout_valid is low.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr] <= bus.req_data;
      end
   end

   assign bus.ack_toggle = ackQ;
   assign bus.dout       = mem[rdPtr];
   assign bus.dout_valid = validQ;
   assign bus.level      = levelQ;
   assign bus.full       = fullQ;
endmodule
